// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit:
// access-size encodings, FSM state type and size decode.
package lsu_pkg;

  localparam logic [3:0] LS_SIZE_B = 4'b0001;
  localparam logic [3:0] LS_SIZE_H = 4'b0010;
  localparam logic [3:0] LS_SIZE_W = 4'b0100;
  localparam logic [3:0] LS_SIZE_D = 4'b1000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN
  } lsu_state_e;

  // Anything that is not a clean one-hot size is handled as a doubleword.
  function automatic logic [3:0] size_bytes(input logic [3:0] size);
    case (size)
      LS_SIZE_B: size_bytes = 4'd1;
      LS_SIZE_H: size_bytes = 4'd2;
      LS_SIZE_W: size_bytes = 4'd4;
      default:   size_bytes = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational datapath of the LSU: misalignment check, store
// shift/mask generation and load extract/extend.
//  chk_addr/chk_size -> misaligned  (incoming request)
//  off/size/is_unsigned/store_data/read_data -> write_data/write_mask/load_data
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [2:0]                     chk_addr,
  input  logic [3:0]                     chk_size,
  output logic                           misaligned,
  input  logic [$clog2(DATA_W/8)-1:0]    off,
  input  logic [3:0]                     size,
  input  logic                           is_unsigned,
  input  logic [63:0]                    store_data,
  input  logic [DATA_W-1:0]              read_data,
  output logic [DATA_W-1:0]              write_data,
  output logic [DATA_W-1:0]              write_mask,
  output logic [63:0]                    load_data
);

  localparam int OFF_W = $clog2(DATA_W/8);

  logic [3:0]       chk_bytes;
  logic [3:0]       bytes;
  logic [OFF_W+2:0] sh;
  logic [63:0]      raw;
  logic [63:0]      base_mask;
  logic             sx;

  assign chk_bytes = size_bytes(chk_size);
  assign bytes     = size_bytes(size);

  // Natural alignment: low address bits under the size must be zero.
  assign misaligned =
    |(chk_addr & 3'(chk_bytes - 4'd1));

  assign sh = {off, 3'b000};
  assign raw = 64'(read_data >> sh);
  assign sx = ~is_unsigned;

  always_comb begin
    load_data = raw;
    base_mask = '1;
    case (bytes)
      4'd1: begin
        load_data = {{56{sx & raw[7]}}, raw[7:0]};
        base_mask = 64'h0000_0000_0000_00ff;
      end
      4'd2: begin
        load_data = {{48{sx & raw[15]}}, raw[15:0]};
        base_mask = 64'h0000_0000_0000_ffff;
      end
      4'd4: begin
        load_data = {{32{sx & raw[31]}}, raw[31:0]};
        base_mask = 64'h0000_0000_ffff_ffff;
      end
      default: ;
    endcase
  end

  assign write_mask = DATA_W'(base_mask) << sh;
  assign write_data = DATA_W'(store_data) << sh;

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store controller: captures one op, issues it on
// the opload/opstore index channels, stalls upstream until done.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 64,
  parameter int INDEX_W = 19
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               is_load,
  input  logic               is_store,
  input  logic               is_unsigned,
  input  logic [3:0]         ls_size,
  input  logic [ADDR_W-1:0]  ls_address,
  input  logic [63:0]        store_data,
  input  logic               flush,
  output logic               out_valid,
  output logic [63:0]        out_load_data,
  output logic               out_misaligned,
  output logic               mem_stall,
  output logic               opload_index_valid,
  input  logic               opload_index_ready,
  output logic [INDEX_W-1:0] opload_index,
  input  logic               opload_operation_done,
  input  logic [DATA_W-1:0]  opload_read_data,
  output logic               opstore_index_valid,
  input  logic               opstore_index_ready,
  output logic [INDEX_W-1:0] opstore_index,
  output logic [DATA_W-1:0]  opstore_write_data,
  output logic [DATA_W-1:0]  opstore_write_mask,
  input  logic               opstore_operation_done
);

  localparam int OFF_W = $clog2(DATA_W/8);
  localparam int IDX_HI = OFF_W + INDEX_W;

  lsu_state_e        state;
  logic              cap_load;
  logic              cap_store;
  logic              cap_unsigned;
  logic [3:0]        cap_size;
  logic [IDX_HI-1:0] cap_addr;
  logic [63:0]       cap_data;

  logic              mem_in;
  logic              mis_in;
  logic              req_ready;
  logic              req_done;
  logic              in_req;
  logic [INDEX_W-1:0] idx;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] wmask;
  logic [63:0]       ld_data;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^ls_address[ADDR_W-1:IDX_HI];

  lsu_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .chk_addr    (ls_address[2:0]),
    .chk_size    (ls_size),
    .misaligned  (mis_in),
    .off         (cap_addr[OFF_W-1:0]),
    .size        (cap_size),
    .is_unsigned (cap_unsigned),
    .store_data  (cap_data),
    .read_data   (opload_read_data),
    .write_data  (wdata),
    .write_mask  (wmask),
    .load_data   (ld_data)
  );

  assign mem_in = is_load | is_store;
  assign in_req = state == REQ;
  assign idx = cap_addr[IDX_HI-1:OFF_W];

  // Only the channel owning the captured op is observed.
  assign req_ready = cap_load ? opload_index_ready
                              : opstore_index_ready;
  assign req_done = cap_load ? opload_operation_done
                             : opstore_operation_done;

  assign in_ready = state == IDLE;
  assign mem_stall = (state != IDLE)
    | (in_valid & mem_in & ~mis_in & ~flush);

  assign opload_index_valid = in_req & cap_load;
  assign opstore_index_valid = in_req & cap_store;
  assign opload_index =
    opload_index_valid ? idx : '0;
  assign opstore_index =
    opstore_index_valid ? idx : '0;
  assign opstore_write_data =
    opstore_index_valid ? wdata : '0;
  assign opstore_write_mask =
    opstore_index_valid ? wmask : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      cap_load       <= 1'b0;
      cap_store      <= 1'b0;
      cap_unsigned   <= 1'b0;
      cap_size       <= '0;
      cap_addr       <= '0;
      cap_data       <= '0;
      out_valid      <= 1'b0;
      out_load_data  <= '0;
      out_misaligned <= 1'b0;
    end else begin
      out_valid      <= 1'b0;
      out_load_data  <= '0;
      out_misaligned <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid && !flush) begin
            // Load wins when both kinds are flagged.
            cap_load     <= is_load;
            cap_store    <= is_store & ~is_load;
            cap_unsigned <= is_unsigned;
            cap_size     <= ls_size;
            cap_addr     <= ls_address[IDX_HI-1:0];
            cap_data     <= store_data;
            if (mem_in && !mis_in) begin
              state <= REQ;
            end else begin
              out_valid      <= 1'b1;
              out_misaligned <= mem_in;
            end
          end
        end
        REQ: begin
          if (req_ready) begin
            // Once accepted, a flush must still wait out the access.
            if (req_done) begin
              state <= IDLE;
              if (!flush) begin
                out_valid     <= 1'b1;
                out_load_data <= cap_load ? ld_data : '0;
              end
            end else begin
              state <= flush ? DRAIN : WAIT;
            end
          end else if (flush) begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (req_done) begin
            state <= IDLE;
            if (!flush) begin
              out_valid     <= 1'b1;
              out_load_data <= cap_load ? ld_data : '0;
            end
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (req_done) state <= IDLE;
        end
      endcase
    end
  end

endmodule
